serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller. Sequences one full_adder cell over two WIDTH-bit

---
 rtl/serial_adder_ctrl_pkg.sv | 14 +
 rtl/serial_adder_ctrl_if.sv | 27 ++
 rtl/serial_adder_ctrl_full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 99 +++++++++
 tb/tb_serial_adder_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
//   sa_state_t   : controller FSM states
//   SA_MAX_WIDTH : largest supported operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Host-side handshake bundle for serial_adder_ctrl.
//   start / a_in / b_in / cin : request and operands (host -> adder)
//   busy / done               : status (adder -> host)
//   sum_out / cout            : registered result (adder -> host)
// master = host side, slave = adder side.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout
  );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell used as the serial bit-slice.
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell walks two WIDTH-bit
// operands LSB first, one bit per clock, carry held in a flip-flop.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_adder_ctrl_if
//          start accepted in IDLE or DONE; busy high during ADD;
//          done pulses one cycle with sum_out/cout valid from that cycle.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  sa_state_t        state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic             c_ff;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, busy_q, done_q;
  logic             fa_s, fa_c;
  logic             load, last;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (c_ff),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
  assign r_nxt = WIDTH'({fa_s, r_sh} >> 1);
  assign load  = bus.start && (state == IDLE || state == DONE);
  assign last  = (state == ADD) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ADD;
      ADD:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      c_ff   <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Status flags registered from the next state so they line up with it.
      busy_q <= (state_nxt == ADD);
      done_q <= (state_nxt == DONE);
      if (load) begin
        a_sh <= bus.a_in;
        b_sh <= bus.b_in;
        c_ff <= bus.cin;
        cnt  <= '0;
      end else if (state == ADD) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        c_ff <= fa_c;
        r_sh <= r_nxt;
        cnt  <= cnt + CNT_W'(1);
        // Result registers only move on the edge entering DONE.
        if (last) begin
          sum_q  <= r_nxt;
          cout_q <= fa_c;
        end
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum_out = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances
// checked against plain-arithmetic expectations.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One add on the 8-bit instance: 1-cycle start, then latency, busy length,
  // result and single-pulse checks against a + b + cin.
  task automatic run_add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input string tag);
    logic [8:0] exp;
    int lat, bc;
    exp = {1'b0, a} + {1'b0, b} + 9'(ci);
    @(negedge clk);
    bus8.a_in = a; bus8.b_in = b; bus8.cin = ci; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
    bc = 0;
    for (lat = 1; lat <= 64; lat++) begin
      if (bus8.done) break;
      if (bus8.busy) bc++;
      @(negedge clk);
    end
    chk({tag, "_lat"},  64'(lat), 64'd9);
    chk({tag, "_busy"}, 64'(bc), 64'd8);
    chk({tag, "_sum"},  64'(bus8.sum_out), 64'(exp[7:0]));
    chk({tag, "_cout"}, 64'(bus8.cout), 64'(exp[8]));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus8.done), 64'd0);
    chk({tag, "_hold"},  64'(bus8.sum_out), 64'(exp[7:0]));
  endtask

  task automatic run_add1(input logic a, input logic b, input logic ci, input string tag);
    logic [1:0] exp;
    int lat;
    exp = 2'(a) + 2'(b) + 2'(ci);
    @(negedge clk);
    bus1.a_in = a; bus1.b_in = b; bus1.cin = ci; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (lat = 1; lat <= 16; lat++) begin
      if (bus1.done) break;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 64'd2);
    chk({tag, "_res"}, 64'({bus1.cout, bus1.sum_out}), 64'(exp));
  endtask

  initial begin
    int ndone, first, d1, d2;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(bus8.busy), 64'd0);
    chk("rst_done", 64'(bus8.done), 64'd0);
    chk("rst_sum",  64'(bus8.sum_out), 64'd0);
    chk("rst_cout", 64'(bus8.cout), 64'd0);
    chk("rst1_res", 64'({bus1.cout, bus1.sum_out, bus1.busy, bus1.done}), 64'd0);

    run_add8(8'h5A, 8'h3C, 1'b0, "t2");
    run_add8(8'hFF, 8'h01, 1'b0, "t3a");
    run_add8(8'hFF, 8'hFF, 1'b1, "t3b");

    // Second start mid-ADD is ignored.
    @(negedge clk);
    bus8.a_in = 8'h10; bus8.b_in = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    ndone = 0; first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus8.start = 1'b0;
      if (c == 3) begin bus8.start = 1'b1; bus8.a_in = 8'hAA; end
      if (c == 4) bus8.start = 1'b0;
      if (bus8.done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    chk("t4_ndone", 64'(ndone), 64'd1);
    chk("t4_lat",   64'(first), 64'd9);
    chk("t4_sum",   64'(bus8.sum_out), 64'h30);

    // Reset mid-ADD discards the partial result.
    @(negedge clk);
    bus8.a_in = 8'h7F; bus8.b_in = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus8.done) ndone++;
      @(negedge clk);
    end
    chk("t5_ndone", 64'(ndone), 64'd0);
    chk("t5_sum",   64'(bus8.sum_out), 64'd0);
    chk("t5_busy",  64'(bus8.busy), 64'd0);
    run_add8(8'h02, 8'h03, 1'b0, "t5b");

    // Back-to-back: start held high across DONE.
    @(negedge clk);
    bus8.a_in = 8'h01; bus8.b_in = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (d1 == 0) begin
          d1 = c;
          chk("t6_sum1", 64'(bus8.sum_out), 64'h02);
          bus8.a_in = 8'h02; bus8.b_in = 8'h02;
        end else if (d2 == 0) begin
          d2 = c;
          chk("t6_sum2", 64'(bus8.sum_out), 64'h04);
          bus8.start = 1'b0;
        end
      end
    end
    bus8.start = 1'b0;
    chk("t6_d1",  64'(d1), 64'd9);
    chk("t6_gap", 64'(d2 - d1), 64'd9);

    for (int i = 0; i < 16; i++)
      run_add8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rnd");

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_add1(v[2], v[1], v[0], "w1");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
